// File: rtl/conv_pkg.sv
// Shared types and default widths for the 1-D convolution sequencing controller.
// Pure declarations: no latency, no flow control.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } conv_state_t;

endpackage

// File: rtl/conv_index_gen.sv
// Inner-loop bounds i_lo = max(0, j-M+1), i_hi = min(j, N-1) for output index j.
// Purely combinational, zero latency, no flow control.
module conv_index_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH:0]   j_i,
  input  logic [ADDR_WIDTH-1:0] size_x_i,
  input  logic [ADDR_WIDTH-1:0] size_y_i,
  output logic [ADDR_WIDTH:0]   i_lo_o,
  output logic [ADDR_WIDTH:0]   i_hi_o
);

  localparam int W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] n_w;
  logic [ADDR_WIDTH:0] m_w;

  always_comb begin
    n_w = {1'b0, size_x_i};
    m_w = {1'b0, size_y_i};
    // Compare before subtracting so j-M+1 never wraps.
    i_lo_o = (j_i >= m_w) ? (j_i - m_w + W'(1)) : '0;
    if (j_i < n_w) begin
      i_hi_o = j_i;
    end else if (n_w == '0) begin
      i_hi_o = '0;
    end else begin
      i_hi_o = n_w - W'(1);
    end
  end

endmodule

// File: rtl/conv_acc_ctrl.sv
// Sequences X/Y reads, accumulator clear/enable and Z writes for z = x * y (full conv).
// Each output j costs K_j+2 cycles; one start at a time, start_i ignored unless idle.
module conv_acc_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] size_x_i,
  input  logic [ADDR_WIDTH-1:0] size_y_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] addr_x_o,
  output logic [ADDR_WIDTH-1:0] addr_y_o,
  output logic                  acc_en_o,
  output logic                  acc_clr_o,
  output logic [ADDR_WIDTH:0]   addr_z_o,
  output logic                  wr_z_o
);

  localparam int W = ADDR_WIDTH + 1;

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 1");
  end

  conv_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] m_q, m_d;
  logic [ADDR_WIDTH:0]   j_q, j_d;
  logic [ADDR_WIDTH:0]   i_q, i_d;
  logic                  en_q, en_d;

  logic [ADDR_WIDTH:0]   j_sel;
  logic [ADDR_WIDTH:0]   i_lo;
  logic [ADDR_WIDTH:0]   i_hi;
  logic [ADDR_WIDTH:0]   last_j;

  // The bound generator looks ahead to the j that the next MAC phase will use.
  always_comb begin
    j_sel = j_q;
    if (state_q == ST_CLR) begin
      j_sel = '0;
    end else if (state_q == ST_WRITE) begin
      j_sel = j_q + W'(1);
    end
  end

  conv_index_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_index_gen (
    .j_i      (j_sel),
    .size_x_i (n_q),
    .size_y_i (m_q),
    .i_lo_o   (i_lo),
    .i_hi_o   (i_hi)
  );

  assign last_j   = {1'b0, n_q} + {1'b0, m_q} - W'(2);
  assign acc_en_o = en_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    j_d       = j_q;
    i_d       = i_q;
    en_d      = 1'b0;
    busy_o    = (state_q != ST_IDLE);
    done_o    = 1'b0;
    addr_x_o  = '0;
    addr_y_o  = '0;
    acc_clr_o = 1'b0;
    addr_z_o  = '0;
    wr_z_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if ((size_x_i != '0) && (size_y_i != '0)) begin
            n_d     = size_x_i;
            m_d     = size_y_i;
            state_d = ST_CLR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLR: begin
        acc_clr_o = 1'b1;
        j_d       = '0;
        i_d       = i_lo;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        addr_x_o = i_q[ADDR_WIDTH-1:0];
        addr_y_o = j_q[ADDR_WIDTH-1:0] - i_q[ADDR_WIDTH-1:0];
        en_d     = 1'b1;
        if (i_q == i_hi) begin
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Clear lands at the clock edge, after the completed sum is written.
        wr_z_o    = 1'b1;
        addr_z_o  = j_q;
        acc_clr_o = 1'b1;
        if (j_q == last_j) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + W'(1);
          i_d     = i_lo;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      j_q     <= '0;
      i_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      j_q     <= j_d;
      i_q     <= i_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: doc/conv_acc_ctrl.md
# conv_acc_ctrl

Sequencing controller for the 1-D convolution datapath. It generates X/Y read addresses and drives the accumulator's enable/clear strobes. It writes each finished sum to the Z memory. It works opposite the accumulating adder register: that block captures and sums products, while this block decides when each capture happens, clears the register, and drains each result out. For sizes N (X) and M (Y) it produces z[j] = Σ x[i]·y[j−i] for j = 0..N+M−2, with i limited to max(0, j−M+1)..min(j, N−1).

## Interface
- DATA_WIDTH, 8, width of the accumulated result (passed through to the datapath, not used internally)
- ADDR_WIDTH, 5, width of the X/Y addresses and size inputs
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  start request; sampled only in IDLE
- size_x_i  in  ADDR_WIDTH  N, the X length; captured at start
- size_y_i  in  ADDR_WIDTH  M, the Y length; captured at start
- busy_o  out  1  high from the cycle after start acceptance through the DONE cycle
- done_o  out  1  one-cycle pulse in DONE
- addr_x_o  out  ADDR_WIDTH  X read address (synchronous-read memory, 1-cycle latency)
- addr_y_o  out  ADDR_WIDTH  Y read address (synchronous-read memory, 1-cycle latency)
- acc_en_o  out  1  accumulator capture enable
- acc_clr_o  out  1  accumulator synchronous clear; has priority over acc_en_o in the register
- addr_z_o  out  ADDR_WIDTH+1  Z write address, equal to j
- wr_z_o  out  1  Z write strobe; data is the accumulator output during that cycle

## Operation
- States: IDLE, CLR, MAC, DRAIN, WRITE, DONE.
- IDLE
  - If start_i = 1 and N ≠ 0 and M ≠ 0: latch N and M, go to CLR.
  - If start_i = 1 and either size is 0: go directly to DONE. No writes occur.
- CLR: acc_clr_o = 1 for one cycle. Set j = 0 and i = i_lo(j). Go to MAC.
- MAC: one address pair per cycle, addr_x_o = i and addr_y_o = j−i.
  - i increments each cycle.
  - After issuing i = i_hi(j), go to DRAIN.
- acc_en_o is a 1-cycle delayed copy of the "MAC address valid" flag, so it lines up with the memory read latency.
- DRAIN: one cycle in which acc_en_o is high for the last product.
- WRITE: wr_z_o = 1, addr_z_o = j, acc_clr_o = 1.
  - The clear takes effect at the end of this cycle, so the written value is the complete sum.
  - If j = N+M−2: go to DONE. Otherwise increment j, reload i = i_lo(j+1), go to MAC.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- Index bounds:
  - i_lo(j) = max(0, j−M+1) and i_hi(j) = min(j, N−1).
  - Compute them with ADDR_WIDTH+1-bit unsigned arithmetic so j−M+1 cannot underflow.
- Arithmetic overflow of the sum is the datapath's concern; the controller ignores it.
- start_i is ignored in every state other than IDLE.
- size_x_i and size_y_i may change freely after acceptance.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- rst asserted mid-operation:
  - Outputs drop to 0 immediately (asynchronously).
  - No further wr_z_o occurs.
  - The block returns to IDLE.
- Cycle numbering: the start_i cycle is cycle 0. CLR is cycle 1. Each output j takes K_j + 2 cycles (K_j = i_hi − i_lo + 1). done_o rises at cycle 2 + Σ_j (K_j + 2).
- Zero size: done_o is high in cycle 1, busy_o is high only in cycle 1, and wr_z_o is never asserted.
- Between two consecutive wr_z_o pulses there are exactly K_{j+1} + 1 cycles.
- acc_en_o is never high in the same cycle as acc_clr_o.

## Structure
- Package conv_pkg holds:
  - the state enum typedef conv_state_t;
  - the default DATA_WIDTH and ADDR_WIDTH constants.
- Sub-module conv_index_gen: a combinational computation of i_lo/i_hi from j, N and M. It is kept separate so it can be unit-tested on its own.
- The FSM, the counters and the en-delay flop live in conv_acc_ctrl.

## Test plan
- N=3, M=2, x={1,2,3}, y={1,1}, with the adder_reg and memories attached:
  - Z receives {1,3,5,3} at addresses 0..3.
  - done_o is high at cycle 16.
- N=1, M=1, x={7}, y={3}:
  - single write z[0] = 21 (mod 2^DATA_WIDTH);
  - wr_z_o high at cycle 4, done_o high at cycle 5.
- size_x_i = 0, start_i pulse: done_o high at cycle 1, no wr_z_o, acc_en_o stays 0.
- start_i pulsed again during MAC of the first case: ignored; results and timing are identical to the first case.
- rst asserted during the second output of the first case: all outputs go to 0 at once. A new start then gives the full, correct {1,3,5,3}.
- N=31, M=31, all ones: 61 writes with z[j] = K_j, where K_j runs 1..31..1. Check there is no address underflow at j ≥ 30.
